// File: rtl/exp4_unidade_controle_if.sv
// Signal bundle between the game control unit and its surroundings
// (player inputs, datapath strobes/status, game result flags).
`timescale 1ns/1ps
interface exp4_unidade_controle_if;
  logic       iniciar;
  logic       jogada;
  logic       chavesIgualMemoria;
  logic       fimC;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, jogada, chavesIgualMemoria, fimC,
    output zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );

  modport slave (
    output iniciar, jogada, chavesIgualMemoria, fimC,
    input  zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );
endinterface

// File: rtl/exp4_unidade_controle.sv
// Control unit of the memory game: walks the player through 16 key entries,
// detects button presses by edge and enforces a per-entry timeout.
`timescale 1ns/1ps
module exp4_unidade_controle #(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input logic                      clock,
  input logic                      reset,
  exp4_unidade_controle_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT_CICLOS);
  localparam logic [CW-1:0] CONT_ULTIMO = CW'(TIMEOUT_CICLOS - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERROU   = 4'hE
  } estado_t;

  typedef struct packed {
    logic zera_c;
    logic conta_c;
    logic zera_r;
    logic registra_r;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } saidas_t;

  // Moore decode; outputs are registered from the next state so they line up with state_r.
  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARACAO:  begin s.zera_c = 1'b1; s.zera_r = 1'b1; end
      REGISTRA:    s.registra_r = 1'b1;
      PROXIMO:     s.conta_c = 1'b1;
      FIM_ACERTOU: begin s.pronto = 1'b1; s.acertou = 1'b1; end
      FIM_ERROU:   begin s.pronto = 1'b1; s.errou = 1'b1; end
      FIM_TIMEOUT: begin s.pronto = 1'b1; s.timeout = 1'b1; end
      default:     s = '0;
    endcase
    return s;
  endfunction

  estado_t       state_r;
  estado_t       next_s;
  saidas_t       saidas_s;
  saidas_t       saidas_r;
  logic [3:0]    db_estado_r;
  logic          jogada_d_r;
  logic          jogada_pulso_s;
  logic [CW-1:0] cont_r;
  logic          cont_fim_s;

  assign jogada_pulso_s = bus.jogada & ~jogada_d_r;
  assign cont_fim_s     = (cont_r == CONT_ULTIMO);

  // Next-state logic; a press beats a timeout expiring in the same cycle.
  always_comb begin
    next_s = state_r;
    case (state_r)
      INICIAL: begin
        if (bus.iniciar) next_s = PREPARACAO;
        else             next_s = INICIAL;
      end
      PREPARACAO: next_s = ESPERA;
      ESPERA: begin
        if (jogada_pulso_s)  next_s = REGISTRA;
        else if (cont_fim_s) next_s = FIM_TIMEOUT;
        else                 next_s = ESPERA;
      end
      REGISTRA: next_s = COMPARACAO;
      COMPARACAO: begin
        if (!bus.chavesIgualMemoria) next_s = FIM_ERROU;
        else if (bus.fimC)           next_s = FIM_ACERTOU;
        else                         next_s = PROXIMO;
      end
      PROXIMO: next_s = ESPERA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
        if (bus.iniciar) next_s = PREPARACAO;
        else             next_s = state_r;
      end
      default: next_s = INICIAL;
    endcase
    saidas_s = decodifica(next_s);
  end

  // State register and registered Moore outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= INICIAL;
      saidas_r    <= '0;
      db_estado_r <= 4'h0;
    end else begin
      state_r     <= next_s;
      saidas_r    <= saidas_s;
      db_estado_r <= next_s;
    end
  end

  // Button edge detector.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) jogada_d_r <= 1'b0;
    else       jogada_d_r <= bus.jogada;
  end

  // Per-entry timeout counter: fresh window on every entry into ESPERA, saturates at the limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont_r <= '0;
    end else if (state_r == ESPERA) begin
      if (!cont_fim_s) cont_r <= cont_r + CW'(1);
      else             cont_r <= cont_r;
    end else begin
      cont_r <= '0;
    end
  end

  assign bus.zeraC     = saidas_r.zera_c;
  assign bus.contaC    = saidas_r.conta_c;
  assign bus.zeraR     = saidas_r.zera_r;
  assign bus.registraR = saidas_r.registra_r;
  assign bus.pronto    = saidas_r.pronto;
  assign bus.acertou   = saidas_r.acertou;
  assign bus.errou     = saidas_r.errou;
  assign bus.timeout   = saidas_r.timeout;
  assign bus.db_estado = db_estado_r;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Scoreboard bench: stimulus queues the expected sequence of output changes
// (with cycle gaps), a monitor pops and compares on every observed change.
`timescale 1ns/1ps
module tb_exp4_unidade_controle;

  localparam logic [7:0] F_NONE    = 8'b0000_0000;
  localparam logic [7:0] F_PREP    = 8'b1010_0000;
  localparam logic [7:0] F_CONTA   = 8'b0100_0000;
  localparam logic [7:0] F_REG     = 8'b0001_0000;
  localparam logic [7:0] F_ACERTOU = 8'b0000_1100;
  localparam logic [7:0] F_ERROU   = 8'b0000_1010;
  localparam logic [7:0] F_TIMEOUT = 8'b0000_1001;

  typedef struct {
    string       name;
    logic [11:0] vec;
    int          gap;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];

  exp4_unidade_controle_if bus ();

  exp4_unidade_controle #(.TIMEOUT_CICLOS(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [11:0] mk(input logic [3:0] est, input logic [7:0] f);
    return {est, f};
  endfunction

  task automatic push(input string name, input logic [11:0] vec, input int gap);
    exp_t e;
    e.name = name;
    e.vec  = vec;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic start();
    push("preparacao", mk(4'h1, F_PREP), -1);
    push("espera", mk(4'h2, F_NONE), 1);
    bus.iniciar = 1'b1;
    @(posedge clock); #2;
    bus.iniciar = 1'b0;
    @(posedge clock); #2;
  endtask

  // One key entry starting in ESPERA; ends at ESPERA or in the end state.
  task automatic entry(input logic eq, input logic fim, input int reg_gap);
    push("registra", mk(4'h4, F_REG), reg_gap);
    push("comparacao", mk(4'h5, F_NONE), 1);
    if (!eq) begin
      push("fim_errou", mk(4'hE, F_ERROU), 1);
    end else if (fim) begin
      push("fim_acertou", mk(4'hA, F_ACERTOU), 1);
    end else begin
      push("proximo", mk(4'h6, F_CONTA), 1);
      push("espera_ret", mk(4'h2, F_NONE), 1);
    end
    bus.jogada = 1'b1;
    bus.chavesIgualMemoria = eq;
    bus.fimC = fim;
    @(posedge clock); #2;
    bus.jogada = 1'b0;
    repeat (3) @(posedge clock);
    #2;
  endtask

  // Monitor: every change of the output vector must match the next queued expectation.
  initial begin : monitor
    logic [11:0] prev;
    logic [11:0] cur;
    int          last_cyc;
    int          gap;
    exp_t        e;
    prev = 12'hFFF;
    last_cyc = 0;
    repeat (2) @(posedge clock);
    forever begin
      @(negedge clock or posedge reset);
      #1;
      cur = {bus.db_estado, bus.zeraC, bus.contaC, bus.zeraR, bus.registraR,
             bus.pronto, bus.acertou, bus.errou, bus.timeout};
      if (cur !== prev) begin
        checks++;
        gap = cyc - last_cyc;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: got vec=%h at cycle %0d, expected no change", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.vec || (e.gap >= 0 && gap != e.gap)) begin
            $display("FAIL %s: got vec=%h gap=%0d, expected vec=%h gap=%0d",
                     e.name, cur, gap, e.vec, e.gap);
          end else begin
            passes++;
          end
        end
        prev = cur;
        last_cyc = cyc;
      end
    end
  end

  initial begin : stimulus
    bus.iniciar = 1'b0;
    bus.jogada = 1'b0;
    bus.chavesIgualMemoria = 1'b0;
    bus.fimC = 1'b0;
    push("reset", mk(4'h0, F_NONE), -1);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #2;

    // Full success: 15 matched entries then the last with fimC.
    start();
    for (int i = 0; i < 15; i++) entry(1'b1, 1'b0, 1);
    entry(1'b1, 1'b1, 1);
    repeat (4) @(posedge clock);
    #2;

    // Error on the third entry; restart clears errou.
    start();
    entry(1'b1, 1'b0, 1);
    entry(1'b1, 1'b0, 1);
    entry(1'b0, 1'b0, 1);
    repeat (3) @(posedge clock);
    #2;

    // No press: timeout exactly 8 cycles after entering ESPERA.
    start();
    push("timeout", mk(4'hD, F_TIMEOUT), 8);
    repeat (12) @(posedge clock);
    #2;

    // Press seen on the last cycle of the window wins over the expiry.
    start();
    repeat (7) @(posedge clock);
    #2;
    entry(1'b1, 1'b0, 8);

    // Held button: one registraR only, iniciar mid-game ignored, then timeout.
    push("held_registra", mk(4'h4, F_REG), 1);
    push("held_comparacao", mk(4'h5, F_NONE), 1);
    push("held_proximo", mk(4'h6, F_CONTA), 1);
    push("held_espera", mk(4'h2, F_NONE), 1);
    push("held_timeout", mk(4'hD, F_TIMEOUT), 8);
    bus.jogada = 1'b1;
    bus.chavesIgualMemoria = 1'b1;
    bus.fimC = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    bus.iniciar = 1'b1;
    @(posedge clock); #2;
    bus.iniciar = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    // Restart with the button still held: no pulse, so it times out again.
    start();
    push("held_restart_timeout", mk(4'hD, F_TIMEOUT), 8);
    repeat (4) @(posedge clock);
    #2;
    bus.jogada = 1'b0;
    repeat (6) @(posedge clock);
    #2;

    // Async reset while in PROXIMO: outputs clear before the next edge.
    start();
    push("rst_registra", mk(4'h4, F_REG), 1);
    push("rst_comparacao", mk(4'h5, F_NONE), 1);
    push("rst_proximo", mk(4'h6, F_CONTA), 1);
    push("rst_async", mk(4'h0, F_NONE), 0);
    bus.jogada = 1'b1;
    @(posedge clock); #2;
    bus.jogada = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock); #2;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    start();
    repeat (3) @(posedge clock);
    #2;

    checks++;
    if (exp_q.size() == 0) begin
      passes++;
    end else begin
      $display("FAIL pending_events: got %0d expected events never observed, expected 0 (next: %s)",
               exp_q.size(), exp_q[0].name);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/exp4_unidade_controle.md
Name: exp4_unidade_controle

Overview:
- Control unit for the memory-checking datapath: sequences the player's 16 key entries against the stored ROM sequence.
- Drives the datapath's address counter and key register through zeraC/contaC/zeraR/registraR.
- Consumes the datapath status signals chavesIgualMemoria and fimC.
- Detects the rising edge of the player's "jogada" button, enforces a per-entry timeout, and reports success, error or timeout to the top level.

Parameters:
- TIMEOUT_CICLOS, 5000, clock cycles allowed in ESPERA before a timeout; legal range 2..2^16-1.

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- iniciar  in  1  start request (level, sampled each cycle)
- jogada  in  1  player key-press level (already synchronised upstream)
- chavesIgualMemoria  in  1  datapath: registered keys equal current ROM word
- fimC  in  1  datapath: address counter at 15 (rco)
- zeraC  out  1  clear address counter (sync, one cycle)
- contaC  out  1  increment address counter
- zeraR  out  1  clear key register
- registraR  out  1  load key register from chaves
- pronto  out  1  game finished (any end state)
- acertou  out  1  all 16 entries matched
- errou  out  1  mismatch detected
- timeout  out  1  player exceeded TIMEOUT_CICLOS
- db_estado  out  4  current state code, for the 7-segment display

Behaviour:
- Reset (async): state=INICIAL, edge-detector flop=0, timeout counter=0; all outputs 0, db_estado=0.
- Moore outputs: decoded from the state register only. No combinational input-to-output paths.
- Edge detector: jogada_d <= jogada every cycle; jogada_pulso = jogada & ~jogada_d. A held button yields exactly one pulse. A pulse is acted on only in ESPERA.
- State codes and transitions:
  - INICIAL (0): all outputs 0. iniciar=1 -> PREPARACAO.
  - PREPARACAO (1): zeraC=1, zeraR=1 for one cycle. -> ESPERA.
  - ESPERA (2): timeout counter increments each cycle.
    - jogada_pulso=1 -> REGISTRA.
    - Else counter==TIMEOUT_CICLOS-1 -> FIM_TIMEOUT.
    - Pulse and expiry in the same cycle: the pulse wins.
  - REGISTRA (4): registraR=1 for one cycle. -> COMPARACAO.
  - COMPARACAO (5): no strobes; register and ROM outputs are stable.
    - chavesIgualMemoria=0 -> FIM_ERROU.
    - Equal and fimC=1 -> FIM_ACERTOU.
    - Equal and fimC=0 -> PROXIMO.
  - PROXIMO (6): contaC=1 for one cycle. -> ESPERA.
  - FIM_ACERTOU (0xA): pronto=1, acertou=1.
  - FIM_ERROU (0xE): pronto=1, errou=1.
  - FIM_TIMEOUT (0xD): pronto=1, timeout=1.
  - End states hold their flags until iniciar=1 -> PREPARACAO. Flags drop on that PREPARACAO cycle.
  - Unused codes -> INICIAL.
- Timeout counter: cleared to 0 on every cycle the state is not ESPERA, so each entry gets a fresh window. Width ceil(log2(TIMEOUT_CICLOS)), saturating.
- Latency: ESPERA->PROXIMO->ESPERA per correct entry is 3 cycles after the detected edge (REGISTRA, COMPARACAO, PROXIMO).
- iniciar asserted mid-game (outside INICIAL/end states): ignored.
- jogada held through an end state and restart: it produces no new pulse, so the next entry requires release and re-press.
- Reset asserted mid-operation: immediate return to INICIAL, all strobes deassert asynchronously.
- At most one of zeraC/contaC/registraR is asserted in any cycle. zeraC and zeraR are always asserted together.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, iniciar=0 -> db_estado=0, all outputs 0. iniciar=1 -> one cycle with zeraC=zeraR=1, then db_estado=2.
- Full success: 16 presses with chavesIgualMemoria=1 and fimC=1 only on the 16th compare -> exactly 15 contaC pulses and 16 registraR pulses, then db_estado=0xA, pronto=acertou=1.
- Error on 3rd entry: chavesIgualMemoria=0 at the 3rd COMPARACAO -> db_estado=0xE, errou=1, contaC count=2. iniciar=1 restarts and clears errou.
- Timeout, TIMEOUT_CICLOS=8: no press after ESPERA entry -> FIM_TIMEOUT exactly 8 cycles later, timeout=1. Press at cycle 7 of ESPERA -> REGISTRA, no timeout.
- Held button: jogada high for 20 cycles -> single registraR pulse. iniciar pulse during ESPERA -> no effect on state.
- Async reset during PROXIMO -> contaC deasserts before the next clock edge, db_estado=0.
